mmu: RTL and testbench

//   Memory-management/bus unit for the pipelined RV32I core (iCE40 target).

---
 rtl/mmu.sv | 122 ++++++++++++
 tb/tb_mmu.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mmu.sv
`default_nettype none
// mmu: data-bus decode, byte-lane placement/extraction and registered instruction fetch.
// Rev 1.0
module mmu #(
   parameter int DM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [31:0] im_addr,
   output logic [31:0] im_do,
   output logic [9:0]  im_addr_out,
   input  logic [31:0] im_data,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_di,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic        is_signed,
   output logic [31:0] dm_do,
   output logic [7:0]  io_addr,
   output logic        io_en,
   output logic        io_we,
   output logic [31:0] io_data_write,
   input  logic [31:0] io_data_read
);
   localparam int         AW      = $clog2(DM_WORDS);
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   logic [31:0]   mem [DM_WORDS];
   logic [31:0]   r_ram_q;
   logic          r_ram_ld;
   logic          r_io_ld;
   logic          r_signed;
   logic [1:0]    r_size;
   logic [4:0]    r_shift;

   logic          w_is_ram;
   logic          w_is_io;
   logic [4:0]    w_shift;
   logic [1:0]    w_size;
   logic [31:0]   w_lane_data;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_src;
   logic [31:0]   w_aligned;
   logic          w_unused_bits;

   assign w_is_ram      = (dm_addr[31:28] == 4'h1);
   assign w_is_io       = (dm_addr[31:28] == 4'h8);
   assign w_idx         = dm_addr[AW+1:2];
   assign w_lane_data   = dm_di << w_shift;
   assign im_addr_out   = im_addr[11:2];
   assign w_unused_bits = &{1'b0, im_addr[31:12], im_addr[1:0], dm_addr[27:AW+2]};

   // Lane is chosen by the lowest enabled byte.
   always_comb begin
      w_shift = 5'd24;
      if (dm_be[0])      w_shift = 5'd0;
      else if (dm_be[1]) w_shift = 5'd8;
      else if (dm_be[2]) w_shift = 5'd16;
   end

   always_comb begin
      case (dm_be)
         4'b1111:          w_size = SZ_WORD;
         4'b0011, 4'b1100: w_size = SZ_HALF;
         default:          w_size = SZ_BYTE;
      endcase
   end

   // No reset on the array so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_is_ram && dm_we) begin
         for (int b = 0; b < 4; b++) begin
            if (dm_be[b]) mem[w_idx][8*b +: 8] <= w_lane_data[8*b +: 8];
         end
      end
      r_ram_q <= mem[w_idx];
   end

   always_ff @(posedge clk or posedge resetb) begin
      if (resetb) begin
         im_do         <= 32'd0;
         r_ram_ld      <= 1'b0;
         r_io_ld       <= 1'b0;
         r_signed      <= 1'b0;
         r_size        <= SZ_BYTE;
         r_shift       <= 5'd0;
         io_en         <= 1'b0;
         io_we         <= 1'b0;
         io_addr       <= 8'd0;
         io_data_write <= 32'd0;
      end else begin
         im_do    <= im_data;
         r_ram_ld <= w_is_ram && !dm_we;
         r_io_ld  <= w_is_io && !dm_we;
         r_signed <= is_signed;
         r_size   <= w_size;
         r_shift  <= w_shift;
         io_en    <= w_is_io;
         io_we    <= w_is_io && dm_we;
         if (w_is_io) begin
            io_addr       <= dm_addr[7:0];
            io_data_write <= w_lane_data;
         end
      end
   end

   // Stores and unmapped accesses leave both load flags clear, forcing dm_do to 0.
   always_comb begin
      w_src = 32'd0;
      if (r_ram_ld)     w_src = r_ram_q;
      else if (r_io_ld) w_src = io_data_read;
      w_aligned = w_src >> r_shift;
      case (r_size)
         SZ_WORD: dm_do = w_aligned;
         SZ_HALF: dm_do = {{16{r_signed & w_aligned[15]}}, w_aligned[15:0]};
         default: dm_do = {{24{r_signed & w_aligned[7]}}, w_aligned[7:0]};
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_mmu.sv
`default_nettype none
// tb_mmu: directed scoreboard bench for mmu.
// Rev 1.0
module tb_mmu;
   logic        clk = 1'b0;
   logic        resetb;
   logic [31:0] im_addr;
   logic [31:0] im_do;
   logic [9:0]  im_addr_out;
   logic [31:0] im_data;
   logic [31:0] dm_addr;
   logic [31:0] dm_di;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic        is_signed;
   logic [31:0] dm_do;
   logic [7:0]  io_addr;
   logic        io_en;
   logic        io_we;
   logic [31:0] io_data_write;
   logic [31:0] io_data_read;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   mmu #(.DM_WORDS(1024)) dut (
      .clk(clk), .resetb(resetb),
      .im_addr(im_addr), .im_do(im_do), .im_addr_out(im_addr_out), .im_data(im_data),
      .dm_addr(dm_addr), .dm_di(dm_di), .dm_we(dm_we), .dm_be(dm_be),
      .is_signed(is_signed), .dm_do(dm_do),
      .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
      .io_data_write(io_data_write), .io_data_read(io_data_read)
   );

   always #5 clk = ~clk;

   // ROM holds 4095-k at word k; IO block returns 4096+k for register k.
   assign im_data      = 32'd4095 - {22'd0, im_addr_out};
   assign io_data_read = 32'd4096 + {26'd0, io_addr[7:2]};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive request, queue the dm_do expected next cycle, then compare.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [3:0] be, input logic sg, input logic [31:0] exp,
                      input string tag);
      exp_t e;
      dm_addr   = a;
      dm_di     = d;
      dm_we     = we;
      dm_be     = be;
      is_signed = sg;
      sb.push_back('{tag, exp});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.tag, dm_do, e.val);
   endtask

   initial begin
      resetb    = 1'b1;
      im_addr   = 32'd0;
      dm_addr   = 32'd0;
      dm_di     = 32'd0;
      dm_we     = 1'b0;
      dm_be     = 4'b1111;
      is_signed = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_im_do", im_do, 32'd0);
      chk("rst_dm_do", dm_do, 32'd0);
      chk("rst_io_en", {31'd0, io_en}, 32'd0);
      chk("rst_io_we", {31'd0, io_we}, 32'd0);
      chk("rst_io_addr", {24'd0, io_addr}, 32'd0);
      chk("rst_io_wdata", io_data_write, 32'd0);
      resetb = 1'b0;

      // Byte lanes: words 0..7, byte i in lane i%4.
      for (int i = 0; i < 32; i++)
         cyc(32'h1000_0000 + 32'(i & ~3), 32'(i), 1'b1, 4'(1 << (i % 4)), 1'b0, 32'd0,
             $sformatf("byte_st%0d", i));
      for (int i = 0; i < 32; i++)
         cyc(32'h1000_0000 + 32'(i & ~3), 32'hFFFF_FFFF, 1'b0, 4'(1 << (i % 4)), 1'b0,
             32'(i), $sformatf("byte_ld%0d", i));

      // Halves: words 8..15, low half 2w, high half 2w+1.
      for (int w = 0; w < 8; w++) begin
         cyc(32'h1000_0020 + 32'(4 * w), 32'(2 * w), 1'b1, 4'b0011, 1'b0, 32'd0,
             $sformatf("half_st_lo%0d", w));
         cyc(32'h1000_0020 + 32'(4 * w), 32'(2 * w + 1), 1'b1, 4'b1100, 1'b0, 32'd0,
             $sformatf("half_st_hi%0d", w));
      end
      for (int w = 0; w < 8; w++) begin
         cyc(32'h1000_0020 + 32'(4 * w), 32'd0, 1'b0, 4'b0011, 1'b1, 32'(2 * w),
             $sformatf("half_ld_lo%0d", w));
         cyc(32'h1000_0020 + 32'(4 * w), 32'd0, 1'b0, 4'b1100, 1'b1, 32'(2 * w + 1),
             $sformatf("half_ld_hi%0d", w));
         cyc(32'h1000_0020 + 32'(4 * w), 32'd0, 1'b0, 4'b1111, 1'b0,
             {16'(2 * w + 1), 16'(2 * w)}, $sformatf("half_pack%0d", w));
      end

      // Words 16..23, then store-then-load of the same word back to back.
      for (int i = 0; i < 8; i++)
         cyc(32'h1000_0040 + 32'(4 * i), 32'(i), 1'b1, 4'b1111, 1'b0, 32'd0,
             $sformatf("word_st%0d", i));
      for (int i = 0; i < 8; i++)
         cyc(32'h1000_0040 + 32'(4 * i), 32'd0, 1'b0, 4'b1111, 1'b0, 32'(i),
             $sformatf("word_ld%0d", i));
      cyc(32'h1000_0068, 32'hDEAD_BEEF, 1'b1, 4'b1111, 1'b0, 32'd0, "raw_st");
      cyc(32'h1000_0068, 32'd0, 1'b0, 4'b1111, 1'b0, 32'hDEAD_BEEF, "raw_ld");

      // Sign extension at the byte and half boundaries.
      cyc(32'h1000_0060, 32'h0000_0080, 1'b1, 4'b0010, 1'b0, 32'd0, "sgn_st_b");
      cyc(32'h1000_0060, 32'd0, 1'b0, 4'b0010, 1'b1, 32'hFFFF_FF80, "sgn_ld_b_s");
      cyc(32'h1000_0060, 32'd0, 1'b0, 4'b0010, 1'b0, 32'h0000_0080, "sgn_ld_b_u");
      cyc(32'h1000_0064, 32'h0000_8001, 1'b1, 4'b1100, 1'b0, 32'd0, "sgn_st_h");
      cyc(32'h1000_0064, 32'd0, 1'b0, 4'b1100, 1'b1, 32'hFFFF_8001, "sgn_ld_h_s");
      cyc(32'h1000_0064, 32'd0, 1'b0, 4'b1100, 1'b0, 32'h0000_8001, "sgn_ld_h_u");

      // Unmapped space: stores vanish, loads read zero, no IO strobe.
      cyc(32'h2000_0040, 32'h1234_5678, 1'b1, 4'b1111, 1'b0, 32'd0, "unm_st");
      chk("unm_st_io_en", {31'd0, io_en}, 32'd0);
      cyc(32'h0000_0040, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd0, "unm_ld0");
      cyc(32'h2000_0040, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd0, "unm_ld2");
      cyc(32'h1000_0040, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd0, "unm_no_alias");

      // Fetch: one cycle of latency through the ROM.
      for (int k = 0; k < 8; k++) begin
         im_addr = 32'(4 * k);
         #1;
         chk($sformatf("im_addr_out%0d", k), {22'd0, im_addr_out}, 32'(k));
         @(posedge clk);
         #1;
         chk($sformatf("fetch%0d", k), im_do, 32'(4095 - k));
      end

      // IO stores and loads.
      for (int k = 0; k < 4; k++) begin
         cyc(32'h8000_0000 + 32'(4 * k), 32'(k), 1'b1, 4'b1111, 1'b0, 32'd0,
             $sformatf("io_st%0d", k));
         chk($sformatf("io_st_en%0d", k), {31'd0, io_en}, 32'd1);
         chk($sformatf("io_st_we%0d", k), {31'd0, io_we}, 32'd1);
         chk($sformatf("io_st_addr%0d", k), {24'd0, io_addr}, 32'(4 * k));
         chk($sformatf("io_st_data%0d", k), io_data_write, 32'(k));
      end
      cyc(32'h8000_0010, 32'h0000_00AB, 1'b1, 4'b0100, 1'b0, 32'd0, "io_st_byte");
      chk("io_st_byte_data", io_data_write, 32'h00AB_0000);
      for (int k = 0; k < 4; k++) begin
         cyc(32'h8000_0000 + 32'(4 * k), 32'd0, 1'b0, 4'b1111, 1'b0, 32'(4096 + k),
             $sformatf("io_ld%0d", k));
         chk($sformatf("io_ld_en%0d", k), {31'd0, io_en}, 32'd1);
         chk($sformatf("io_ld_we%0d", k), {31'd0, io_we}, 32'd0);
      end
      cyc(32'h1000_0040, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd0, "io_idle_ld");
      chk("io_idle_en", {31'd0, io_en}, 32'd0);

      // Reset while an IO load is pending discards it.
      cyc(32'h8000_0020, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd4104, "io_ld_pre_rst");
      chk("pre_rst_io_en", {31'd0, io_en}, 32'd1);
      resetb = 1'b1;
      #1;
      chk("mid_rst_io_en", {31'd0, io_en}, 32'd0);
      chk("mid_rst_dm_do", dm_do, 32'd0);
      chk("mid_rst_io_addr", {24'd0, io_addr}, 32'd0);
      dm_addr = 32'd0;
      @(posedge clk);
      #1;
      resetb = 1'b0;
      cyc(32'h1000_0044, 32'd0, 1'b0, 4'b1111, 1'b0, 32'd1, "ram_kept_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
